// File: rtl/wash_sched_pkg.sv
// rtl/wash_sched_pkg.sv - shared types, defaults and round-robin pick for the wash job scheduler
package wash_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    START  = 2'd1,
    SETTLE = 2'd2
  } sched_state_e;

  localparam int N_MACH_DEF  = 4;
  localparam int Q_DEPTH_DEF = 4;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } rr_pick_t;

  // First idle machine at or after ptr, modulo n; busy bits above n must read as 1.
  function automatic rr_pick_t rr_pick(input logic [7:0] busy, input logic [2:0] ptr, input int n);
    rr_pick_t r;
    int       idx;
    r = '0;
    for (int i = 7; i >= 0; i--) begin
      if (i < n) begin
        idx = int'(ptr) + i;
        if (idx >= n) idx = idx - n;
        if (!busy[3'(idx)]) begin
          r.found = 1'b1;
          r.idx   = 3'(idx);
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/wash_job_fifo.sv
// rtl/wash_job_fifo.sv - 1-bit wide pending-job FIFO holding the double-wash flag
module wash_job_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     push_data,
  input  logic                     pop,
  output logic                     pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0] mem;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push & !full;
  assign do_pop   = pop & !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wash_job_scheduler.sv
// rtl/wash_job_scheduler.sv - queues paid wash jobs and dispatches them round-robin to idle machines
module wash_job_scheduler
  import wash_sched_pkg::*;
#(
  parameter int N_MACH  = N_MACH_DEF,
  parameter int Q_DEPTH = Q_DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       job_valid,
  input  logic                       job_double,
  output logic                       job_ready,
  input  logic [N_MACH-1:0]          mach_done,
  output logic [N_MACH-1:0]          mach_start,
  output logic [N_MACH-1:0]          mach_double,
  output logic [N_MACH-1:0]          mach_busy,
  output logic [$clog2(Q_DEPTH):0]   queue_count,
  output logic                       all_busy,
  output logic                       done_err
);
  sched_state_e      state;
  sched_state_e      state_next;
  logic [2:0]        rr_ptr;
  logic [2:0]        rr_next;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_head;
  logic              push;
  logic              pop;
  logic [7:0]        busy_pad;
  rr_pick_t          pick;
  logic [N_MACH-1:0] grant_vec;

  assign job_ready = !fifo_full;
  assign all_busy  = &mach_busy;
  assign push      = job_valid & !fifo_full;

  wash_job_fifo #(.DEPTH(Q_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (job_double),
    .pop       (pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (queue_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    busy_pad               = '1;
    busy_pad[N_MACH-1:0]   = mach_busy;
    pick                   = rr_pick(busy_pad, rr_ptr, N_MACH);
    state_next             = state;
    pop                    = 1'b0;
    grant_vec              = '0;
    rr_next                = rr_ptr;
    case (state)
      IDLE: begin
        if (!fifo_empty && pick.found) begin
          pop        = 1'b1;
          grant_vec  = {{(N_MACH-1){1'b0}}, 1'b1} << pick.idx;
          rr_next    = pick.idx + 3'd1;
          if (rr_next == 3'(N_MACH)) rr_next = '0;
          state_next = START;
        end
      end
      START:   state_next = SETTLE;
      SETTLE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A grant only targets an idle machine, so it never collides with a done clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr      <= '0;
      mach_start  <= '0;
      mach_double <= '0;
      mach_busy   <= '0;
      done_err    <= 1'b0;
    end else begin
      rr_ptr      <= rr_next;
      mach_start  <= grant_vec;
      mach_double <= grant_vec & {N_MACH{fifo_head}};
      mach_busy   <= (mach_busy & ~mach_done) | grant_vec;
      if (|(mach_done & ~mach_busy)) done_err <= 1'b1;
    end
  end

endmodule
